// File: rtl/mips_cpu_harvard_ram_pkg.sv
// Shared types, constants and helpers for the Harvard test memory.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_WAIT,
        PS_READY
    } port_state_t;

    // Word 0 of the array aliases this byte address through address wrap.
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/mips_cpu_harvard_ram_if.sv
// Avalon-style waitrequest bus used by both memory ports.
interface mips_cpu_harvard_ram_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_cpu_mem_port_fsm.sv
// Per-port handshake FSM: latches the request, counts wait states and
// flags the edges where read data is sampled or a write commits.
// A request takes WAIT+2 cycles: one IDLE cycle, WAIT cycles in PS_WAIT, one READY cycle.
module mips_cpu_mem_port_fsm
    import mips_mem_pkg::*;
#(
    parameter int unsigned WAIT   = 0,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] index_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic              waitrequest_o,
    output logic              capture_o,        // readdata samples the array at this edge
    output logic [ADDR_W-1:0] capture_index_o,
    output logic              commit_o,         // latched write lands at this edge
    output logic [ADDR_W-1:0] index_o,
    output logic [3:0]        be_o,
    output logic [31:0]       wdata_o
);

    localparam logic [3:0] WaitCnt  = 4'(WAIT);
    localparam logic [3:0] WaitLoad = (WAIT == 0) ? 4'd0 : WaitCnt - 4'd1;

    port_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic              req;

    // Read and write together count as a write.
    assign req = read_i | write_i;

    // State and latched request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PS_IDLE;
            cnt_q      <= '0;
            index_q    <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            index_q    <= index_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
        end
    end

    // Next-state and latch logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        index_d    = index_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        unique case (state_q)
            PS_IDLE: begin
                if (req) begin
                    index_d    = index_i;
                    be_d       = be_i;
                    wdata_d    = wdata_i;
                    is_write_d = write_i;
                    if (WAIT == 0) begin
                        state_d = PS_READY;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = PS_WAIT;
                    end
                end
            end
            PS_WAIT: begin
                // A request dropped mid-wait is abandoned without side effects.
                if (!req) begin
                    state_d = PS_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = PS_READY;
                end
            end
            PS_READY: state_d = PS_IDLE;
            default:  state_d = PS_IDLE;
        endcase
    end

    // Handshake and array-strobe outputs.
    always_comb begin
        waitrequest_o   = 1'b0;
        capture_o       = 1'b0;
        commit_o        = 1'b0;
        capture_index_o = index_q;
        unique case (state_q)
            PS_IDLE: begin
                waitrequest_o   = req;
                // With no wait states the read is sampled straight from the live address.
                capture_o       = (WAIT == 0) && read_i && !write_i;
                capture_index_o = index_i;
            end
            PS_WAIT: begin
                waitrequest_o = 1'b1;
                capture_o     = req && (cnt_q == 4'd0) && !is_write_q;
            end
            PS_READY: commit_o = is_write_q;
            default:  waitrequest_o = 1'b1;
        endcase
        if (!reset_n) begin
            waitrequest_o = 1'b1;
            capture_o     = 1'b0;
            commit_o      = 1'b0;
        end
    end

    assign index_o = index_q;
    assign be_o    = be_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/mips_cpu_harvard_ram.sv
// Harvard test memory: one word array shared by an instruction port and a
// byte-writable data port, with an optional write-protected boot region.
module mips_cpu_harvard_ram
    import mips_mem_pkg::*;
#(
    parameter string       RAM_INIT_FILE = "",
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned INSTR_WAIT    = 0,
    parameter int unsigned DATA_WAIT     = 1,
    parameter int unsigned BOOT_WORDS    = 256,
    parameter bit          BOOT_WP       = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mips_cpu_harvard_ram_if.slave   instr_bus,
    mips_cpu_harvard_ram_if.slave   data_bus
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [31:0]       mem_q [Depth];
    logic [31:0]       instr_rdata_q;
    logic [31:0]       data_rdata_q;
    logic [15:0]       wp_drop_count;

    logic              instr_capture;
    logic [ADDR_W-1:0] instr_cap_idx;
    logic              instr_commit;
    logic [ADDR_W-1:0] instr_idx;
    logic [3:0]        instr_be;
    logic [31:0]       instr_wdata;

    logic              data_capture;
    logic [ADDR_W-1:0] data_cap_idx;
    logic              data_commit;
    logic [ADDR_W-1:0] data_idx;
    logic [3:0]        data_be;
    logic [31:0]       data_wdata;
    logic              wp_hit;

    // Array starts zeroed; the array is never touched by reset.
    initial begin
        for (int i = 0; i < Depth; i++) begin
            mem_q[i] = '0;
        end
    end

    // Instruction port never writes.
    mips_cpu_mem_port_fsm #(
        .WAIT   (INSTR_WAIT),
        .ADDR_W (ADDR_W)
    ) u_instr_fsm (
        .clk             (clk),
        .reset_n         (reset_n),
        .read_i          (instr_bus.read),
        .write_i         (1'b0),
        .index_i         (instr_bus.address[ADDR_W+1:2]),
        .be_i            (4'h0),
        .wdata_i         (32'h0),
        .waitrequest_o   (instr_bus.waitrequest),
        .capture_o       (instr_capture),
        .capture_index_o (instr_cap_idx),
        .commit_o        (instr_commit),
        .index_o         (instr_idx),
        .be_o            (instr_be),
        .wdata_o         (instr_wdata)
    );

    mips_cpu_mem_port_fsm #(
        .WAIT   (DATA_WAIT),
        .ADDR_W (ADDR_W)
    ) u_data_fsm (
        .clk             (clk),
        .reset_n         (reset_n),
        .read_i          (data_bus.read),
        .write_i         (data_bus.write),
        .index_i         (data_bus.address[ADDR_W+1:2]),
        .be_i            (data_bus.byteenable),
        .wdata_i         (data_bus.writedata),
        .waitrequest_o   (data_bus.waitrequest),
        .capture_o       (data_capture),
        .capture_index_o (data_cap_idx),
        .commit_o        (data_commit),
        .index_o         (data_idx),
        .be_o            (data_be),
        .wdata_o         (data_wdata)
    );

    assign wp_hit = BOOT_WP && (32'(data_idx) < BOOT_WORDS);

    // Data-port write commit; same-edge instruction reads see the old word.
    always_ff @(posedge clk) begin
        if (data_commit && !wp_hit) begin
            mem_q[data_idx] <= byte_merge(mem_q[data_idx], data_wdata, data_be);
        end
    end

    // Registered read data for both ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            if (instr_capture) instr_rdata_q <= mem_q[instr_cap_idx];
            if (data_capture)  data_rdata_q  <= mem_q[data_cap_idx];
        end
    end

    // Saturating count of writes dropped by boot-region protection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_drop_count <= '0;
        end else if (data_commit && wp_hit && (wp_drop_count != 16'hFFFF)) begin
            wp_drop_count <= wp_drop_count + 16'd1;
        end
    end

    assign instr_bus.readdata = instr_rdata_q;
    assign data_bus.readdata  = data_rdata_q;

endmodule

// File: tb/tb_mips_cpu_harvard_ram.sv
// Directed self-checking bench for mips_cpu_harvard_ram.
module tb_mips_cpu_harvard_ram;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_bad = 0;

    mips_cpu_harvard_ram_if ibus ();
    mips_cpu_harvard_ram_if dbus ();

    mips_cpu_harvard_ram #(
        .RAM_INIT_FILE (""),
        .ADDR_W        (10),
        .INSTR_WAIT    (0),
        .DATA_WAIT     (3),
        .BOOT_WORDS    (2),
        .BOOT_WP       (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .instr_bus (ibus),
        .data_bus  (dbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Runs one handshake starting just after a rising edge; returns cycles taken
    // (including the READY cycle) and readdata seen while waitrequest was low.
    task automatic xfer(input bit is_data, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata,
                        output int cycles, output logic [31:0] rdata);
        logic wreq;
        rdata = '0;
        if (is_data) begin
            dbus.address    = addr;
            dbus.read       = rd;
            dbus.write      = wr;
            dbus.byteenable = be;
            dbus.writedata  = wdata;
        end else begin
            ibus.address = addr;
            ibus.read    = rd;
        end
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            wreq = is_data ? dbus.waitrequest : ibus.waitrequest;
            if (!wreq) rdata = is_data ? dbus.readdata : ibus.readdata;
            @(posedge clk);
            #1;
        end while (wreq && cycles < 40);
        if (is_data) begin
            dbus.read  = 1'b0;
            dbus.write = 1'b0;
        end else begin
            ibus.read = 1'b0;
        end
        check("handshake_done", {31'b0, wreq}, 32'd0);
    endtask

    int          cyc;
    int          cyc_i;
    logic [31:0] rd;
    logic [31:0] rd_i;

    initial begin
        ibus.address = '0; ibus.read = 1'b0; ibus.write = 1'b0;
        ibus.byteenable = '0; ibus.writedata = '0;
        dbus.address = '0; dbus.read = 1'b0; dbus.write = 1'b0;
        dbus.byteenable = '0; dbus.writedata = '0;

        // Boot image after the array's own zero fill.
        #2;
        dut.mem_q[0] = 32'h24020005;
        dut.mem_q[1] = 32'hCAFE0001;
        dut.mem_q[2] = 32'h11110002;

        #1;
        check("rst_instr_wait", {31'b0, ibus.waitrequest}, 32'd1);
        check("rst_data_wait",  {31'b0, dbus.waitrequest}, 32'd1);
        check("rst_instr_rdata", ibus.readdata, 32'h0);
        check("rst_data_rdata",  dbus.readdata, 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_req_wait", {31'b0, ibus.waitrequest}, 32'd0);

        // Fetch from the reset vector: one wait cycle, data in cycle 2.
        xfer(1'b0, 1'b1, 1'b0, RESET_VECTOR, 4'h0, 32'h0, cyc, rd);
        check("fetch_cycles", cyc, 2);
        check("fetch_data", rd, 32'h24020005);

        xfer(1'b1, 1'b0, 1'b1, 32'h400, 4'hF, 32'hDEADBEEF, cyc, rd);
        check("wr400_cycles", cyc, 5);
        xfer(1'b1, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, cyc, rd);
        check("rd400_cycles", cyc, 5);
        check("rd400_data", rd, 32'hDEADBEEF);

        xfer(1'b1, 1'b0, 1'b1, 32'h400, 4'b0010, 32'h00001100, cyc, rd);
        xfer(1'b1, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, cyc, rd);
        check("be0010_data", rd, 32'hDEAD11EF);

        // Empty byte enable and wrapped address.
        xfer(1'b1, 1'b0, 1'b1, 32'h400, 4'h0, 32'hFFFFFFFF, cyc, rd);
        check("be0000_cycles", cyc, 5);
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC00400, 4'h0, 32'h0, cyc, rd);
        check("be0000_wrap_data", rd, 32'hDEAD11EF);

        // Protected boot word.
        xfer(1'b1, 1'b0, 1'b1, 32'h4, 4'hF, 32'h12345678, cyc, rd);
        check("wp_cycles", cyc, 5);
        xfer(1'b1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, cyc, rd);
        check("wp_word", rd, 32'hCAFE0001);
        check("wp_drop_count", {16'h0, dut.wp_drop_count}, 32'd1);

        // Read and write together act as a write; readdata keeps the last read.
        xfer(1'b1, 1'b1, 1'b1, 32'h404, 4'hF, 32'hA5A5A5A5, cyc, rd);
        check("rdwr_rdata_hold", rd, 32'hCAFE0001);
        xfer(1'b1, 1'b1, 1'b0, 32'h404, 4'h0, 32'h0, cyc, rd);
        check("rdwr_written", rd, 32'hA5A5A5A5);

        // Fetch of word 2 captured on the edge the data write to word 2 commits.
        fork
            xfer(1'b1, 1'b0, 1'b1, 32'h8, 4'hF, 32'h99990008, cyc, rd);
            begin
                repeat (4) @(posedge clk);
                #1;
                xfer(1'b0, 1'b1, 1'b0, 32'hBFC00008, 4'h0, 32'h0, cyc_i, rd_i);
            end
        join
        check("coll_wr_cycles", cyc, 5);
        check("coll_old_word", rd_i, 32'h11110002);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC00008, 4'h0, 32'h0, cyc_i, rd_i);
        check("coll_new_word", rd_i, 32'h99990008);

        // Reset in the middle of a write.
        dbus.address = 32'h400; dbus.writedata = 32'h77777777;
        dbus.byteenable = 4'hF; dbus.write = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_wait", {31'b0, dbus.waitrequest}, 32'd1);
        check("midrst_rdata", dbus.readdata, 32'h0);
        check("midrst_instr_rdata", ibus.readdata, 32'h0);
        dbus.write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1'b1, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, cyc, rd);
        check("midrst_word_kept", rd, 32'hDEAD11EF);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
